// File: rtl/ifu_mem_arbiter.sv
// Shares a single memory port between instruction fetch (IF, read-only) and load/store (LS).
// Define IFU_ARB_PERF_EN to add grant and IF-stall performance counters.
module ifu_mem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int WMASK_W       = 4,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [DATA_WIDTH-1:0] if_req_addr,
    input  logic                  if_flush,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic [DATA_WIDTH-1:0] ls_req_addr,
    input  logic                  ls_req_wen,
    input  logic [DATA_WIDTH-1:0] ls_req_wdata,
    input  logic [WMASK_W-1:0]    ls_req_wmask,
    output logic                  ls_rsp_valid,
    output logic [DATA_WIDTH-1:0] ls_rsp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [WMASK_W-1:0]    mem_req_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data
`ifdef IFU_ARB_PERF_EN
    ,
    output logic [31:0]           perf_if_grants,
    output logic [31:0]           perf_ls_grants,
    output logic [31:0]           perf_if_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

    state_t                state_reg, state_next;
    logic                  owner_ls_reg;
    logic                  drop_reg;
    logic [3:0]            streak_reg;
    logic                  mem_req_valid_reg;
    logic [DATA_WIDTH-1:0] mem_req_addr_reg;
    logic                  mem_req_wen_reg;
    logic [DATA_WIDTH-1:0] mem_req_wdata_reg;
    logic [WMASK_W-1:0]    mem_req_wmask_reg;
    logic                  if_rsp_valid_reg;
    logic [DATA_WIDTH-1:0] if_rsp_data_reg;
    logic                  ls_rsp_valid_reg;
    logic [DATA_WIDTH-1:0] ls_rsp_data_reg;

    logic if_eff;
    logic grant_ls;
    logic grant_if;
    logic hs_if;
    logic hs_ls;
    logic rsp_done;

    // A flushed fetch never competes; LS yields only once its streak limit is reached.
    assign if_eff   = if_req_valid & ~if_flush;
    assign grant_ls = ls_req_valid & (~if_eff | (streak_reg < STREAK_MAX));
    assign grant_if = if_eff & ~grant_ls;
    assign hs_if    = if_req_ready;
    assign hs_ls    = ls_req_ready;
    assign rsp_done = (state_reg == WAIT) & mem_rsp_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                if_req_ready = rst & grant_if;
                ls_req_ready = rst & grant_ls;
                if (grant_if | grant_ls) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_ls_reg      <= 1'b0;
            drop_reg          <= 1'b0;
            mem_req_valid_reg <= 1'b0;
            mem_req_addr_reg  <= '0;
            mem_req_wen_reg   <= 1'b0;
            mem_req_wdata_reg <= '0;
            mem_req_wmask_reg <= '0;
            if_rsp_valid_reg  <= 1'b0;
            if_rsp_data_reg   <= '0;
            ls_rsp_valid_reg  <= 1'b0;
            ls_rsp_data_reg   <= '0;
        end else begin
            if_rsp_valid_reg <= 1'b0;
            ls_rsp_valid_reg <= 1'b0;
            if (hs_if | hs_ls) begin
                owner_ls_reg      <= hs_ls;
                drop_reg          <= 1'b0;
                mem_req_valid_reg <= 1'b1;
                mem_req_addr_reg  <= hs_ls ? ls_req_addr : if_req_addr;
                mem_req_wen_reg   <= hs_ls & ls_req_wen;
                mem_req_wdata_reg <= hs_ls ? ls_req_wdata : '0;
                mem_req_wmask_reg <= hs_ls ? ls_req_wmask : '0;
            end
            if ((state_reg == REQ) && mem_req_ready) begin
                mem_req_valid_reg <= 1'b0;
            end
            if ((state_reg != IDLE) && !owner_ls_reg && if_flush) begin
                drop_reg <= 1'b1;
            end
            // A flush arriving together with the response still kills the fetch result.
            if (rsp_done) begin
                drop_reg <= 1'b0;
                if (owner_ls_reg) begin
                    ls_rsp_valid_reg <= 1'b1;
                    ls_rsp_data_reg  <= mem_rsp_data;
                end else if (!(drop_reg | if_flush)) begin
                    if_rsp_valid_reg <= 1'b1;
                    if_rsp_data_reg  <= mem_rsp_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            streak_reg <= '0;
        end else if (hs_ls) begin
            if (!if_eff) begin
                streak_reg <= '0;
            end else if (streak_reg != 4'hF) begin
                streak_reg <= streak_reg + 4'd1;
            end
        end else if (hs_if) begin
            streak_reg <= '0;
        end
    end

    assign mem_req_valid = mem_req_valid_reg;
    assign mem_req_addr  = mem_req_addr_reg;
    assign mem_req_wen   = mem_req_wen_reg;
    assign mem_req_wdata = mem_req_wdata_reg;
    assign mem_req_wmask = mem_req_wmask_reg;
    assign if_rsp_valid  = if_rsp_valid_reg;
    assign if_rsp_data   = if_rsp_data_reg;
    assign ls_rsp_valid  = ls_rsp_valid_reg;
    assign ls_rsp_data   = ls_rsp_data_reg;

`ifdef IFU_ARB_PERF_EN
    logic [31:0] perf_if_grants_reg;
    logic [31:0] perf_ls_grants_reg;
    logic [31:0] perf_if_stall_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_if_grants_reg <= '0;
            perf_ls_grants_reg <= '0;
            perf_if_stall_reg  <= '0;
        end else begin
            if (hs_if) begin
                perf_if_grants_reg <= perf_if_grants_reg + 32'd1;
            end
            if (hs_ls) begin
                perf_ls_grants_reg <= perf_ls_grants_reg + 32'd1;
            end
            if (if_req_valid && !if_req_ready) begin
                perf_if_stall_reg <= perf_if_stall_reg + 32'd1;
            end
        end
    end

    assign perf_if_grants = perf_if_grants_reg;
    assign perf_ls_grants = perf_ls_grants_reg;
    assign perf_if_stall  = perf_if_stall_reg;
`endif

endmodule

// File: tb/tb_ifu_mem_arbiter.sv
// Bench for ifu_mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_ifu_mem_arbiter;
    localparam int DW     = 32;
    localparam int MW     = 4;
    localparam int MAX_LS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid, if_req_ready, if_flush, if_rsp_valid;
    logic [DW-1:0] if_req_addr, if_rsp_data;
    logic          ls_req_valid, ls_req_ready, ls_req_wen, ls_rsp_valid;
    logic [DW-1:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
    logic [MW-1:0] ls_req_wmask;
    logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
    logic [DW-1:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic [MW-1:0] mem_req_wmask;
`ifdef IFU_ARB_PERF_EN
    logic [31:0]   perf_if_grants, perf_ls_grants, perf_if_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_mem_arbiter #(
        .DATA_WIDTH(DW), .WMASK_W(MW), .MAX_LS_STREAK(MAX_LS)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
        .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef IFU_ARB_PERF_EN
        ,
        .perf_if_grants(perf_if_grants), .perf_ls_grants(perf_ls_grants), .perf_if_stall(perf_if_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
        ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_wen = 1'b0;
        ls_req_wdata = '0; ls_req_wmask = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Memory side: wait for a request, stall, accept, then answer after lat cycles.
    // Returns in the cycle right after mem_rsp_valid was driven.
    task automatic mem_serve(input int stall, input int lat, input logic [DW-1:0] data, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (mem_req_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (mem_req_valid !== 1'b1) return;
        for (int i = 0; i < stall; i++) begin
            mem_req_ready = 1'b0;
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 1; i < lat; i++) tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        tick();
        mem_rsp_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        idle_inputs();
        rst = 1'b0;
        if_req_valid = 1'b1; ls_req_valid = 1'b1; ls_req_wen = 1'b1;
        ls_req_addr = 32'h1234_5678; ls_req_wdata = 32'hFFFF_FFFF; ls_req_wmask = 4'hF;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
        repeat (2) begin
            tick();
            #1;
            checks++;
            if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_req_valid, mem_req_wen} !== 6'b0 ||
                if_rsp_data !== '0 || ls_rsp_data !== '0 || mem_req_addr !== '0 ||
                mem_req_wdata !== '0 || mem_req_wmask !== '0) begin
                errors++;
                $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h wmask=%h if_d=%h ls_d=%h, required all 0",
                         {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_req_valid, mem_req_wen},
                         mem_req_addr, mem_req_wdata, mem_req_wmask, if_rsp_data, ls_rsp_data);
            end
        end
        idle_inputs();
        rst = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h8000_0000;
        #1;
        checks++;
        if (if_req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_if_ready: got %b, required 1", if_req_ready);
        end
        tick();
        if_req_valid = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 || mem_req_wen !== 1'b0 || mem_req_wmask !== '0) begin
            errors++;
            $display("FAIL reset_if_memreq: valid=%b addr=%h wen=%b wmask=%h, required 1 80000000 0 0",
                     mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask);
        end
        mem_serve(0, 2, 32'h0000_0413, ok);
        #1;
        checks++;
        if (!ok || if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h0000_0413 || ls_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_if_rsp: served=%0d valid=%b data=%h ls_valid=%b, required 1 1 00000413 0",
                     ok, if_rsp_valid, if_rsp_data, ls_rsp_valid);
        end
        tick();
        checks++;
        if (if_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_if_pulse_len: valid=%b, required 0", if_rsp_valid);
        end
    endtask

    task automatic test_priority();
        bit ok;
        apply_reset();
        if_req_valid = 1'b1; if_req_addr = 32'h0000_1000;
        ls_req_valid = 1'b1; ls_req_addr = 32'h0000_2000; ls_req_wen = 1'b0;
        #1;
        checks++;
        if (ls_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
            errors++; $display("FAIL prio_first_grant: ls=%b if=%b, required ls=1 if=0", ls_req_ready, if_req_ready);
        end
        tick();
        ls_req_valid = 1'b0;
        checks++;
        if (mem_req_addr !== 32'h0000_2000 || mem_req_wen !== 1'b0) begin
            errors++; $display("FAIL prio_ls_addr: addr=%h wen=%b, required 00002000 0", mem_req_addr, mem_req_wen);
        end
        mem_serve(0, 1, 32'hCAFE_0001, ok);
        #1;
        checks++;
        if (!ok || ls_rsp_valid !== 1'b1 || ls_rsp_data !== 32'hCAFE_0001 || if_rsp_valid !== 1'b0 || if_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_ls_rsp_if_grant: served=%0d ls_v=%b ls_d=%h if_v=%b if_rdy=%b, required 1 1 cafe0001 0 1",
                     ok, ls_rsp_valid, ls_rsp_data, if_rsp_valid, if_req_ready);
        end
        tick();
        if_req_valid = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1000) begin
            errors++; $display("FAIL prio_if_req: valid=%b addr=%h, required 1 00001000", mem_req_valid, mem_req_addr);
        end
        mem_serve(0, 1, 32'h0000_0013, ok);
        #1;
        checks++;
        if (!ok || if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h0000_0013 || ls_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_if_rsp: served=%0d if_v=%b if_d=%h ls_v=%b, required 1 1 00000013 0",
                     ok, if_rsp_valid, if_rsp_data, ls_rsp_valid);
        end
    endtask

    task automatic test_streak();
        bit ok;
        string got, exp;
        apply_reset();
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0100;
        ls_req_valid = 1'b1; ls_req_addr = 32'h0000_0200;
        for (int g = 0; g < 10; g++) begin
            #1;
            exp = ((g % (MAX_LS + 1)) == MAX_LS) ? "IF" : "LS";
            got = (ls_req_ready && if_req_ready) ? "BOTH" : ls_req_ready ? "LS" : if_req_ready ? "IF" : "NONE";
            checks++;
            if (got != exp) begin
                errors++; $display("FAIL streak_order[%0d]: granted %s, required %s", g, got, exp);
            end
            tick();
            mem_serve(0, 1, DW'(g), ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL streak_mem_timeout[%0d]: no memory request, required one", g);
            end
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        bit ok;
        apply_reset();
        if_req_valid = 1'b1; if_flush = 1'b1; if_req_addr = 32'h0000_3000;
        #1;
        checks++;
        if (if_req_ready !== 1'b0) begin
            errors++; $display("FAIL flush_idle_mask: if_ready=%b, required 0", if_req_ready);
        end
        tick();
        if_flush = 1'b0;
        #1;
        checks++;
        if (if_req_ready !== 1'b1) begin
            errors++; $display("FAIL flush_idle_unmask: if_ready=%b, required 1", if_req_ready);
        end
        tick();
        if_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0;
        repeat (2) begin
            #1;
            checks++;
            if (if_rsp_valid !== 1'b0 || if_rsp_data !== '0) begin
                errors++; $display("FAIL flush_wait_drop: valid=%b data=%h, required 0 00000000", if_rsp_valid, if_rsp_data);
            end
            tick();
        end
        if_req_valid = 1'b1; if_req_addr = 32'h0000_3004;
        #1;
        checks++;
        if (if_req_ready !== 1'b1) begin
            errors++; $display("FAIL flush_next_ready: if_ready=%b, required 1", if_req_ready);
        end
        tick();
        if_req_valid = 1'b0;
        mem_serve(0, 1, 32'h00A0_0093, ok);
        #1;
        checks++;
        if (!ok || if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h00A0_0093) begin
            errors++; $display("FAIL flush_next_rsp: served=%0d valid=%b data=%h, required 1 1 00a00093", ok, if_rsp_valid, if_rsp_data);
        end
        tick();
        if_req_valid = 1'b1; if_req_addr = 32'h0000_3008;
        tick();
        if_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; if_flush = 1'b1; mem_rsp_data = 32'h1111_1111;
        tick();
        mem_rsp_valid = 1'b0; if_flush = 1'b0;
        #1;
        checks++;
        if (if_rsp_valid !== 1'b0 || if_rsp_data !== 32'h00A0_0093) begin
            errors++; $display("FAIL flush_same_cycle: valid=%b data=%h, required 0 00a00093", if_rsp_valid, if_rsp_data);
        end
    endtask

    task automatic test_write_stall();
        apply_reset();
        ls_req_valid = 1'b1; ls_req_wen = 1'b1; ls_req_addr = 32'h8000_1000;
        ls_req_wdata = 32'h1234_5678; ls_req_wmask = 4'hF;
        #1;
        checks++;
        if (ls_req_ready !== 1'b1) begin
            errors++; $display("FAIL write_ready: ls_ready=%b, required 1", ls_req_ready);
        end
        tick();
        ls_req_valid = 1'b0; ls_req_wen = 1'b0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_wmask = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !==
                {1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF}) begin
                errors++;
                $display("FAIL write_stall_hold[%0d]: valid=%b addr=%h wen=%b wdata=%h wmask=%h, required 1 80001000 1 12345678 f",
                         i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
            end
            mem_req_ready = (i == 3);
            tick();
        end
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL write_valid_drop: valid=%b, required 0", mem_req_valid);
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA5A5_A5A5;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 32'hA5A5_A5A5 || if_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL write_rsp: ls_v=%b ls_d=%h if_v=%b, required 1 a5a5a5a5 0", ls_rsp_valid, ls_rsp_data, if_rsp_valid);
        end
        tick();
        checks++;
        if (ls_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL write_pulse_len: ls_v=%b, required 0", ls_rsp_valid);
        end
    endtask

    task automatic test_reset_wait();
        bit ok;
        apply_reset();
        if_req_valid = 1'b1; if_req_addr = 32'h0000_4000;
        tick();
        if_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || if_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rstwait_idle: mem_v=%b if_v=%b, required 0 0", mem_req_valid, if_rsp_valid);
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0055;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0 || if_rsp_data !== '0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_ignore: if_v=%b ls_v=%b if_d=%h mem_v=%b, required 0 0 00000000 0",
                     if_rsp_valid, ls_rsp_valid, if_rsp_data, mem_req_valid);
        end
        if_req_valid = 1'b1; if_req_addr = 32'h0000_4004;
        #1;
        checks++;
        if (if_req_ready !== 1'b1) begin
            errors++; $display("FAIL rstwait_regrant: if_ready=%b, required 1", if_req_ready);
        end
        tick();
        if_req_valid = 1'b0;
        mem_serve(0, 1, 32'h0000_0077, ok);
        #1;
        checks++;
        if (!ok || if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h0000_0077) begin
            errors++; $display("FAIL rstwait_after: served=%0d valid=%b data=%h, required 1 1 00000077", ok, if_rsp_valid, if_rsp_data);
        end
    endtask

    // Transaction-level model: one transaction outstanding from handshake until the memory answers.
    task automatic test_random();
        bit            busy, accepted, owner_ls, drop, if_eff, want_ls, exp_if_rdy, exp_ls_rdy, exp_if_p, exp_ls_p;
        int            streak, wait_cnt;
        logic [DW-1:0] t_addr, t_wdata, exp_if_d, exp_ls_d;
        logic          t_wen;
        logic [MW-1:0] t_wmask;
        apply_reset();
        busy = 0; accepted = 0; owner_ls = 0; drop = 0; streak = 0; wait_cnt = 0;
        exp_if_p = 0; exp_ls_p = 0; exp_if_d = '0; exp_ls_d = '0;
        t_addr = '0; t_wdata = '0; t_wen = 1'b0; t_wmask = '0;
        for (int c = 0; c < 3000; c++) begin
            checks++;
            if (mem_req_valid !== (busy && !accepted)) begin
                errors++; $display("FAIL rand_mem_valid@%0d: got %b, required %b", c, mem_req_valid, busy && !accepted);
            end
            if (busy && !accepted) begin
                checks++;
                if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== {t_addr, t_wen, t_wdata, t_wmask}) begin
                    errors++;
                    $display("FAIL rand_mem_fields@%0d: got %h/%b/%h/%h, required %h/%b/%h/%h", c,
                             mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, t_addr, t_wen, t_wdata, t_wmask);
                end
            end
            checks++;
            if (if_rsp_valid !== exp_if_p || ls_rsp_valid !== exp_ls_p || if_rsp_data !== exp_if_d || ls_rsp_data !== exp_ls_d) begin
                errors++;
                $display("FAIL rand_rsp@%0d: if %b/%h ls %b/%h, required if %b/%h ls %b/%h", c,
                         if_rsp_valid, if_rsp_data, ls_rsp_valid, ls_rsp_data, exp_if_p, exp_if_d, exp_ls_p, exp_ls_d);
            end
            if_req_valid  = ($urandom_range(0, 9) < 6);
            if_req_addr   = $urandom;
            if_flush      = ($urandom_range(0, 9) == 0);
            ls_req_valid  = ($urandom_range(0, 9) < 5);
            ls_req_addr   = $urandom;
            ls_req_wen    = 1'($urandom_range(0, 1));
            ls_req_wdata  = $urandom;
            ls_req_wmask  = MW'($urandom);
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_rsp_data  = $urandom;
            if (busy && accepted) begin
                mem_rsp_valid = (wait_cnt == 1);
                if (wait_cnt > 1) wait_cnt--;
            end else begin
                mem_rsp_valid = ($urandom_range(0, 9) == 0);
            end
            #1;
            if_eff     = if_req_valid && !if_flush;
            want_ls    = ls_req_valid && (!if_eff || streak < MAX_LS);
            exp_ls_rdy = !busy && want_ls;
            exp_if_rdy = !busy && if_eff && !want_ls;
            checks++;
            if (ls_req_ready !== exp_ls_rdy || if_req_ready !== exp_if_rdy) begin
                errors++;
                $display("FAIL rand_ready@%0d: ls=%b if=%b, required ls=%b if=%b", c, ls_req_ready, if_req_ready, exp_ls_rdy, exp_if_rdy);
            end
            exp_if_p = 0;
            exp_ls_p = 0;
            if (busy && !owner_ls && if_flush) drop = 1;
            if (busy && accepted && mem_rsp_valid) begin
                busy = 0;
                if (owner_ls) begin
                    exp_ls_p = 1; exp_ls_d = mem_rsp_data;
                end else if (!drop) begin
                    exp_if_p = 1; exp_if_d = mem_rsp_data;
                end
                drop = 0;
            end else if (busy && !accepted && mem_req_ready) begin
                accepted = 1;
                wait_cnt = $urandom_range(1, 3);
            end
            if (exp_ls_rdy) begin
                busy = 1; accepted = 0; owner_ls = 1; drop = 0;
                t_addr = ls_req_addr; t_wen = ls_req_wen; t_wdata = ls_req_wdata; t_wmask = ls_req_wmask;
                streak = if_eff ? ((streak < 15) ? streak + 1 : 15) : 0;
            end else if (exp_if_rdy) begin
                busy = 1; accepted = 0; owner_ls = 0; drop = 0;
                t_addr = if_req_addr; t_wen = 1'b0; t_wdata = '0; t_wmask = '0;
                streak = 0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_priority();
        test_streak();
        test_flush();
        test_write_stall();
        test_reset_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
